// File: rtl/rvtu_div_arb.sv
// rvtu_div_arb: round-robin arbiter sharing one iterative divider among NREQ cores,
// returning each result as a one-cycle resp pulse to the granted core.
module rvtu_div_arb #(
  parameter int NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*32-1:0]  src1,
  input  logic [NREQ*32-1:0]  src2,
  input  logic [NREQ*2-1:0]   fsel,
  output logic [NREQ-1:0]     resp,
  output logic [31:0]         out,
  output logic                dv_start,
  output logic [31:0]         dv_src1,
  output logic [31:0]         dv_src2,
  output logic [1:0]          dv_fsel,
  input  logic                dv_done,
  input  logic [31:0]         dv_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  localparam logic [IDXW:0] N = (IDXW+1)'(NREQ);
  state_t state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d, rr_q, rr_d, win, nxt;
  logic [NREQ-1:0] mask_q, mask_d, elig, gmask;
  logic [31:0] out_q, out_d, s1_q, s1_d, s2_q, s2_d;
  logic [1:0] fs_q, fs_d;
  logic found;
  logic [IDXW:0] sum, inc;
  assign elig = req & ~mask_q;
  assign gmask = NREQ'(1) << grant_q;
  assign inc = {1'b0, grant_q} + (IDXW+1)'(1);
  assign nxt = inc == N ? '0 : inc[IDXW-1:0];
  // scan downward so the smallest offset from rr_q is the final winner
  always_comb begin
    found = 1'b0;
    win = '0;
    sum = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (IDXW+1)'(k);
      sum = sum >= N ? sum - N : sum;
      if (elig[sum[IDXW-1:0]]) begin
        found = 1'b1;
        win = sum[IDXW-1:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
      mask_q <= '0;
      out_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      fs_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      mask_q <= mask_d;
      out_q <= out_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      fs_q <= fs_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    mask_d = mask_q;
    out_d = out_q;
    s1_d = s1_q;
    s2_d = s2_q;
    fs_d = fs_q;
    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (found) begin
          state_d = ISSUE;
          grant_d = win;
          s1_d = src1[{win, 5'd0} +: 32];
          s2_d = src2[{win, 5'd0} +: 32];
          fs_d = fsel[{win, 1'b0} +: 2];
        end
      end
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (dv_done) begin
          out_d = dv_out;
          state_d = req[grant_q] ? RESP : IDLE;
          rr_d = req[grant_q] ? rr_q : nxt;
        end
      end
      RESP: begin
        rr_d = nxt;
        mask_d = gmask;
        state_d = IDLE;
      end
    endcase
  end
  always_comb begin
    dv_start = state_q == ISSUE;
    resp = state_q == RESP ? gmask : '0;
    out = out_q;
    dv_src1 = s1_q;
    dv_src2 = s2_q;
    dv_fsel = fs_q;
  end
  dv_done_in_busy: assert property (@(posedge clk) disable iff (!rst) dv_done |-> state_q == BUSY);
endmodule

// File: tb/tb_rvtu_div_arb.sv
// tb_rvtu_div_arb: scoreboard bench for rvtu_div_arb with a behavioural divider model.
module tb_rvtu_div_arb;
  localparam int NREQ = 4;
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic [1:0] f;} launch_t;
  typedef struct packed {logic [NREQ-1:0] r; logic [31:0] o;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*32-1:0] src1 = '0;
  logic [NREQ*32-1:0] src2 = '0;
  logic [NREQ*2-1:0] fsel = '0;
  logic [NREQ-1:0] resp;
  logic [31:0] out, dv_src1, dv_src2, dv_out;
  logic dv_start, dv_done;
  logic [1:0] dv_fsel;
  launch_t lq[$];
  rsp_t rq[$];
  int nvec = 0, nerr = 0, cyc = 0, last_done = 0, gap = 0, lat = 5;
  logic prev_done = 1'b0;
  logic [NREQ-1:0] served = '0, late = '0, lated = '0;

  rvtu_div_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .src1(src1), .src2(src2), .fsel(fsel),
    .resp(resp), .out(out), .dv_start(dv_start), .dv_src1(dv_src1),
    .dv_src2(dv_src2), .dv_fsel(dv_fsel), .dv_done(dv_done), .dv_out(dv_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dvf(logic [31:0] a, logic [31:0] b, logic [1:0] f);
    case (f)
      2'd0: dvf = $signed(a) / $signed(b);
      2'd1: dvf = a / b;
      2'd2: dvf = $signed(a) % $signed(b);
      default: dvf = a % b;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic bad(string name);
    nvec++;
    nerr++;
    $display("FAIL %s", name);
  endtask

  task automatic issue(int i, logic [31:0] a, logic [31:0] b, logic [1:0] f, bit want, logic [31:0] o);
    src1[32*i +: 32] = a;
    src2[32*i +: 32] = b;
    fsel[2*i +: 2] = f;
    lq.push_back(launch_t'{a: a, b: b, f: f});
    if (want) rq.push_back(rsp_t'{r: NREQ'(1) << i, o: o});
    req[i] = 1'b1;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while ((lq.size() != 0 || rq.size() != 0 || req != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (lq.size() != 0 || rq.size() != 0 || req != 0) begin
      bad({name, " timeout"});
      lq.delete();
      rq.delete();
      req = '0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(string name);
    int n;
    n = 0;
    while (lq.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (lq.size() != 0) bad({name, " launch timeout"});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [31:0] res;
    cnt = 0;
    res = '0;
    dv_done = 1'b0;
    dv_out = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        cnt = 0;
        dv_done = 1'b0;
      end else begin
        dv_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            dv_done = 1'b1;
            dv_out = res;
          end
        end
        if (dv_start) begin
          cnt = lat;
          res = dvf(dv_src1, dv_src2, dv_fsel);
        end
      end
    end
  end

  initial begin
    launch_t l;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (dv_start) begin
          gap = cyc - last_done;
          if (lq.size() == 0) bad("unexpected launch");
          else begin
            l = lq.pop_front();
            chk("launch src1", dv_src1, l.a);
            chk("launch src2", dv_src2, l.b);
            chk("launch fsel", dv_fsel, l.f);
          end
        end
        if (|resp) begin
          chk("resp follows dv_done", prev_done, 1);
          chk("resp with dv_start", dv_start, 0);
          if (rq.size() == 0) bad("unexpected resp");
          else begin
            r = rq.pop_front();
            chk("resp vector", resp, r.r);
            chk("resp out", out, r.o);
          end
          served |= resp;
        end
        if (dv_done) last_done = cyc;
        prev_done = dv_done;
      end else prev_done = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (served[i]) begin
        if (late[i] && !lated[i]) lated[i] = 1'b1;
        else begin
          req[i] = 1'b0;
          served[i] = 1'b0;
          lated[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset resp", resp, 0);
    chk("reset out", out, 0);
    chk("reset dv_start", dv_start, 0);
    chk("reset dv_src1", dv_src1, 0);
    chk("reset dv_src2", dv_src2, 0);
    chk("reset dv_fsel", dv_fsel, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    issue(1, 100, 7, 2'd0, 1'b1, 14);
    @(negedge clk);
    chk("dv_start in req cycle", dv_start, 0);
    @(negedge clk);
    chk("dv_start one cycle after req", dv_start, 1);
    wait_done("single core");
    do_reset();
    @(posedge clk); #1;
    issue(0, 200, 10, 2'd1, 1'b1, 20);
    issue(2, 32'hFFFF_FFEC, 3, 2'd0, 1'b1, 32'hFFFF_FFFA);
    issue(3, 50, 8, 2'd3, 1'b1, 2);
    wait_done("order 0,2,3");
    issue(1, 9, 2, 2'd2, 1'b1, 1);
    issue(3, 81, 9, 2'd1, 1'b1, 9);
    wait_done("rr back at 0");
    late = 4'b0010;
    issue(1, 77, 7, 2'd1, 1'b1, 11);
    issue(2, 35, 6, 2'd2, 1'b1, 5);
    wait_done("late drop with core 2");
    issue(1, 64, 4, 2'd1, 1'b1, 16);
    wait_done("late drop alone");
    late = '0;
    issue(0, 1000, 10, 2'd1, 1'b0, 0);
    wait_launch("flush");
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b0;
    issue(1, 1000, 3, 2'd3, 1'b1, 1);
    wait_done("flush");
    chk("relaunch gap after abort", gap, 2);
    issue(2, 12, 4, 2'd1, 1'b1, 3);
    wait_done("rr to 3");
    issue(3, 7, 7, 2'd1, 1'b1, 1);
    issue(0, 15, 4, 2'd3, 1'b1, 3);
    wait_done("wrap 3,0");
    issue(1, 45, 9, 2'd1, 1'b1, 5);
    issue(0, 30, 5, 2'd1, 1'b1, 6);
    wait_done("rr at 1");
    issue(2, 8, 2, 2'd1, 1'b1, 4);
    wait_done("rr to 3 again");
    issue(2, 99, 9, 2'd1, 1'b0, 0);
    wait_launch("reset mid-busy");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async rst resp", resp, 0);
    chk("async rst out", out, 0);
    chk("async rst dv_start", dv_start, 0);
    chk("async rst dv_src1", dv_src1, 0);
    chk("async rst dv_src2", dv_src2, 0);
    chk("async rst dv_fsel", dv_fsel, 0);
    repeat (2) @(posedge clk);
    #1;
    issue(2, 99, 9, 2'd1, 1'b1, 11);
    issue(3, 144, 12, 2'd1, 1'b1, 12);
    rst = 1'b1;
    wait_done("after reset");
    chk("launch queue drained", lq.size(), 0);
    chk("resp queue drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
